ex_mem_reg: RTL

EX/MEM pipeline register of the MIPS processor, sitting directly downstream of `alu_module`. Captures the ALU result and zero flag with store data, destination register, memory/writeback control bits and the computed branch target. Drives the data-memory and writeback stages and resolves branches in MEM via `pc_src`. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/mips_defs.sv | 38 +++
 rtl/ex_mem_reg_branch_adder.sv | 23 ++
 rtl/ex_mem_reg.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// ---------------------------------------------------------------------------
// Module : mips_defs (package)
// Shared datapath widths, ALU select encodings and the MEM/WB control bundle.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_defs;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6
    } alu_sel_e;

    // Control bits carried from EX into MEM/WB.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctl_t;

    localparam ctl_t CTL_NOP = '0;

    // A bundle belonging to a non-instruction must never assert anything.
    function automatic ctl_t ctl_qualify(input ctl_t c, input logic v);
        return v ? c : CTL_NOP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_reg_branch_adder.sv
// ---------------------------------------------------------------------------
// Module : branch_adder
// Branch target = pc_plus4 + (imm << 2), wrapping at W bits.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] pc_plus4,
    input  logic [W-1:0] imm,
    output logic [W-1:0] target
);

    logic [W-1:0] imm_x4;

    assign imm_x4 = imm << 2;
    assign target = pc_plus4 + imm_x4;

endmodule

`default_nettype wire

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// Module : ex_mem_reg
// EX/MEM pipeline register with stall/flush and MEM-stage branch resolution.
// Optional BNE support is enabled by defining EX_MEM_BNE_EN.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_mem_reg #(
    parameter int DW = mips_defs::DW,
    parameter int RW = mips_defs::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          valid_i,
    input  logic [DW-1:0] alu_res_i,
    input  logic          zero_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic [DW-1:0] pc_plus4_i,
    input  logic [DW-1:0] imm_i,
    input  logic [RW-1:0] wr_reg_i,
    input  logic          reg_write_i,
    input  logic          mem_read_i,
    input  logic          mem_write_i,
    input  logic          mem_to_reg_i,
    input  logic          branch_i,
`ifdef EX_MEM_BNE_EN
    input  logic          branch_ne_i,
`endif
    output logic          valid_o,
    output logic [DW-1:0] alu_res_o,
    output logic [DW-1:0] rt_data_o,
    output logic [DW-1:0] br_target_o,
    output logic          zero_o,
    output logic [RW-1:0] wr_reg_o,
    output logic          reg_write_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic          mem_to_reg_o,
    output logic          pc_src
);

    import mips_defs::*;

    ctl_t          ctl_in;
    ctl_t          ctl_q;
    ctl_t          ctl_out;
    logic          valid_q;
    logic          zero_q;
    logic [DW-1:0] alu_q;
    logic [DW-1:0] rt_q;
    logic [DW-1:0] br_q;
    logic [DW-1:0] br_sum;
    logic [RW-1:0] wr_q;

    always_comb begin
        ctl_in            = CTL_NOP;
        ctl_in.reg_write  = reg_write_i;
        ctl_in.mem_to_reg = mem_to_reg_i;
        ctl_in.mem_read   = mem_read_i;
        ctl_in.mem_write  = mem_write_i;
        ctl_in.branch     = branch_i;
    end

    branch_adder #(
        .W (DW)
    ) u_branch_adder (
        .pc_plus4 (pc_plus4_i),
        .imm      (imm_i),
        .target   (br_sum)
    );

    // Flush outranks stall so the hazard unit can kill a held instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctl_q   <= CTL_NOP;
            zero_q  <= 1'b0;
            alu_q   <= '0;
            rt_q    <= '0;
            br_q    <= '0;
            wr_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctl_q   <= CTL_NOP;
            zero_q  <= 1'b0;
            alu_q   <= '0;
            rt_q    <= '0;
            br_q    <= '0;
            wr_q    <= '0;
        end else if (!stall) begin
            valid_q <= valid_i;
            ctl_q   <= ctl_qualify(ctl_in, valid_i);
            zero_q  <= zero_i;
            alu_q   <= alu_res_i;
            rt_q    <= rt_data_i;
            br_q    <= br_sum;
            wr_q    <= wr_reg_i;
        end
    end

`ifdef EX_MEM_BNE_EN
    logic bne_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bne_q <= 1'b0;
        end else if (flush) begin
            bne_q <= 1'b0;
        end else if (!stall) begin
            bne_q <= branch_ne_i & valid_i;
        end
    end

    assign pc_src = valid_q & ((ctl_q.branch & zero_q) | (bne_q & ~zero_q));
`else
    assign pc_src = valid_q & ctl_q.branch & zero_q;
`endif

    assign ctl_out      = ctl_qualify(ctl_q, valid_q);
    assign valid_o      = valid_q;
    assign alu_res_o    = alu_q;
    assign rt_data_o    = rt_q;
    assign br_target_o  = br_q;
    assign zero_o       = zero_q;
    assign wr_reg_o     = wr_q;
    assign reg_write_o  = ctl_out.reg_write;
    assign mem_read_o   = ctl_out.mem_read;
    assign mem_write_o  = ctl_out.mem_write;
    assign mem_to_reg_o = ctl_out.mem_to_reg;

endmodule

`default_nettype wire
